qf105_wb_mailbox: RTL and testbench

//  Wishbone classic slave on the Caravel management bus (wbs_*); feeds the mkQF105 core.

---
 rtl/qf105_wb_mailbox_if.sv | 13 +
 rtl/qf105_wb_mailbox.sv | 100 ++++++++++
 tb/tb_qf105_wb_mailbox.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/qf105_wb_mailbox_if.sv
// qf105_wb_mailbox_if: Wishbone classic bus bundle between the management SoC and the mailbox.
interface qf105_wb_mailbox_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;
    modport master(output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
    modport slave(input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/qf105_wb_mailbox.sv
// qf105_wb_mailbox: Wishbone mailbox with m2c/c2m FIFOs and a level interrupt for the mkQF105 core.
module qf105_wb_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    qf105_wb_mailbox_if.slave  wbs,
    output logic               m2c_valid_o,
    output logic [31:0]        m2c_data_o,
    input  logic               m2c_ready_i,
    input  logic               c2m_valid_i,
    input  logic [31:0]        c2m_data_i,
    output logic               c2m_ready_o,
    output logic               irq_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   m2c_mem_q [DEPTH];
    logic [31:0]   c2m_mem_q [DEPTH];
    logic [PW-1:0] m2c_wp_q, m2c_rp_q, c2m_wp_q, c2m_rp_q;
    logic [CW-1:0] m2c_cnt_q, m2c_cnt_d, c2m_cnt_q, c2m_cnt_d;
    logic          ack_q, tx_drop_q, tx_drop_d, c2m_rdy_q, irq_q;
    logic [1:0]    en_q, en_d;
    logic [31:0]   dat_q, dat_d, status;
    logic [1:0]    reg_sel;
    logic          hit, wr, rd, m2c_push, m2c_pop, c2m_push, c2m_pop;
    logic          unused_ok;

    assign reg_sel  = wbs.adr[3:2];
    assign hit      = wbs.cyc & wbs.stb & (wbs.adr[31:4] == BASE_ADDR[31:4]) & !ack_q;
    assign wr       = hit & wbs.we;
    assign rd       = hit & !wbs.we;
    // Full is judged on the registered count, so a same-cycle core pop cannot rescue a TX write
    assign m2c_push = wr & (reg_sel == 2'd0) & (m2c_cnt_q != FULL);
    assign m2c_pop  = m2c_valid_o & m2c_ready_i;
    assign c2m_push = c2m_valid_i & c2m_rdy_q;
    assign c2m_pop  = rd & (reg_sel == 2'd1) & (c2m_cnt_q != '0);
    assign unused_ok = ^{wbs.sel[3], wbs.sel[1], wbs.adr[1:0]};

    assign wbs.ack     = ack_q;
    assign wbs.dat_r   = dat_q;
    assign m2c_valid_o = m2c_cnt_q != '0;
    assign m2c_data_o  = m2c_valid_o ? m2c_mem_q[m2c_rp_q] : '0;
    assign c2m_ready_o = c2m_rdy_q;
    assign irq_o       = irq_q;

    always_comb begin
        status         = '0;
        status[CW-1:0] = m2c_cnt_q;
        status[8+:CW]  = c2m_cnt_q;
        status[16]     = tx_drop_q;
        m2c_cnt_d = m2c_cnt_q + CW'(m2c_push) - CW'(m2c_pop);
        c2m_cnt_d = c2m_cnt_q + CW'(c2m_push) - CW'(c2m_pop);
        tx_drop_d = (wr & (reg_sel == 2'd0) & (m2c_cnt_q == FULL)) |
                    (tx_drop_q & !(wr & (reg_sel == 2'd2) & wbs.sel[2] & wbs.dat_w[16]));
        en_d  = (wr & (reg_sel == 2'd3) & wbs.sel[0]) ? wbs.dat_w[1:0] : en_q;
        dat_d = !rd                ? '0 :
                reg_sel == 2'd1    ? (c2m_pop ? c2m_mem_q[c2m_rp_q] : '0) :
                reg_sel == 2'd2    ? status :
                reg_sel == 2'd3    ? {30'b0, en_q} : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            m2c_wp_q  <= '0;
            m2c_rp_q  <= '0;
            c2m_wp_q  <= '0;
            c2m_rp_q  <= '0;
            m2c_cnt_q <= '0;
            c2m_cnt_q <= '0;
            tx_drop_q <= 1'b0;
            en_q      <= '0;
            c2m_rdy_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= hit;
            dat_q     <= dat_d;
            m2c_wp_q  <= m2c_wp_q + PW'(m2c_push);
            m2c_rp_q  <= m2c_rp_q + PW'(m2c_pop);
            c2m_wp_q  <= c2m_wp_q + PW'(c2m_push);
            c2m_rp_q  <= c2m_rp_q + PW'(c2m_pop);
            m2c_cnt_q <= m2c_cnt_d;
            c2m_cnt_q <= c2m_cnt_d;
            tx_drop_q <= tx_drop_d;
            en_q      <= en_d;
            c2m_rdy_q <= c2m_cnt_d != FULL;
            irq_q     <= (en_q[0] & (c2m_cnt_q != '0)) | (en_q[1] & (m2c_cnt_q == '0));
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (m2c_push) m2c_mem_q[m2c_wp_q] <= wbs.dat_w;
        if (c2m_push) c2m_mem_q[c2m_wp_q] <= c2m_data_i;
    end
endmodule

// File: tb/tb_qf105_wb_mailbox.sv
// tb_qf105_wb_mailbox: directed checks of the Wishbone mailbox against hand-computed values.
module tb_qf105_wb_mailbox;
    localparam logic [31:0] TX = 32'h3000_0000;
    localparam logic [31:0] RX = 32'h3000_0004;
    localparam logic [31:0] ST = 32'h3000_0008;
    localparam logic [31:0] IE = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m2c_valid, m2c_ready, c2m_valid, c2m_ready, irq;
    logic [31:0] m2c_data, c2m_data, rdat;
    int          n_cmp = 0;
    int          n_bad = 0;

    qf105_wb_mailbox_if bus ();

    qf105_wb_mailbox dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (bus.slave),
        .m2c_valid_o(m2c_valid),
        .m2c_data_o (m2c_data),
        .m2c_ready_i(m2c_ready),
        .c2m_valid_i(c2m_valid),
        .c2m_data_i (c2m_data),
        .c2m_ready_o(c2m_ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_w = dat; bus.sel = sel;
        @(posedge clk); #1;
        check("ack_high", {31'b0, bus.ack}, 32'd1);
        rd = bus.dat_r;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
        check("ack_low", {31'b0, bus.ack}, 32'd0);
    endtask

    task automatic core_push(input logic [31:0] d);
        @(negedge clk);
        c2m_valid = 1'b1; c2m_data = d;
        @(negedge clk);
        c2m_valid = 1'b0;
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = 4'h0; bus.adr = '0; bus.dat_w = '0;
        m2c_ready = 1'b0; c2m_valid = 1'b0; c2m_data = '0;
        #12;
        check("rst_ack", {31'b0, bus.ack}, 32'd0);
        check("rst_dat", bus.dat_r, 32'd0);
        check("rst_m2c_valid", {31'b0, m2c_valid}, 32'd0);
        check("rst_c2m_ready", {31'b0, c2m_ready}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("c2m_ready_after_rst", {31'b0, c2m_ready}, 32'd1);
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_rst", rdat, 32'd0);

        wb(1'b1, TX, 32'hDEADBEEF, 4'hF, rdat);
        check("m2c_valid", {31'b0, m2c_valid}, 32'd1);
        check("m2c_data", m2c_data, 32'hDEADBEEF);
        @(negedge clk); m2c_ready = 1'b1;
        @(negedge clk); m2c_ready = 1'b0;
        check("m2c_valid_popped", {31'b0, m2c_valid}, 32'd0);
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_after_pop", rdat, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            wb(1'b1, TX, i, 4'hF, rdat);
            wb(1'b0, ST, 0, 4'hF, rdat);
            check("status_fill", rdat, (i >= 5 ? 32'h1_0000 : 32'h0) | (i > 4 ? 32'd4 : i));
        end
        wb(1'b1, ST, 32'h1_0000, 4'b0100, rdat);
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_drop_clr", rdat, 32'd4);
        @(negedge clk); m2c_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", m2c_data, i + 1);
            @(negedge clk);
        end
        m2c_ready = 1'b0;
        check("drain_empty", {31'b0, m2c_valid}, 32'd0);

        core_push(32'h11);
        core_push(32'h22);
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_c2m2", rdat, 32'h200);
        wb(1'b0, RX, 0, 4'hF, rdat); check("rx_0", rdat, 32'h11);
        wb(1'b0, RX, 0, 4'hF, rdat); check("rx_1", rdat, 32'h22);
        wb(1'b0, RX, 0, 4'hF, rdat); check("rx_empty", rdat, 32'h0);
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_c2m0", rdat, 32'h0);

        wb(1'b1, IE, 32'd1, 4'b0001, rdat);
        check("irq_en1_idle", {31'b0, irq}, 32'd0);
        @(negedge clk); c2m_valid = 1'b1; c2m_data = 32'h5A;
        @(posedge clk); #1; c2m_valid = 1'b0;
        check("irq_lag", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_set", {31'b0, irq}, 32'd1);
        wb(1'b0, RX, 0, 4'hF, rdat); check("rx_5a", rdat, 32'h5A);
        check("irq_clr", {31'b0, irq}, 32'd0);
        wb(1'b1, IE, 32'd2, 4'b0001, rdat);
        check("irq_m2c_empty", {31'b0, irq}, 32'd1);
        wb(1'b0, IE, 0, 4'hF, rdat); check("ie_read", rdat, 32'd2);
        wb(1'b1, IE, 32'd0, 4'b0001, rdat);

        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h3000_0010; bus.dat_w = 32'h99; bus.sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; check("miss_no_ack", {31'b0, bus.ack}, 32'd0);
        end
        @(negedge clk); bus.cyc = 1'b0; bus.adr = TX;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; check("nocyc_no_ack", {31'b0, bus.ack}, 32'd0);
        end
        @(negedge clk); bus.stb = 1'b0; bus.we = 1'b0;
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_no_change", rdat, 32'd0);

        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = TX; bus.dat_w = 32'h77;
        @(posedge clk); #1;
        check("ack_before_rst", {31'b0, bus.ack}, 32'd1);
        rst_n = 1'b0; #1;
        check("ack_async_rst", {31'b0, bus.ack}, 32'd0);
        check("m2c_async_rst", {31'b0, m2c_valid}, 32'd0);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        wb(1'b0, ST, 0, 4'hF, rdat); check("status_after_rst", rdat, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
